// File: rtl/tlb_if.sv
// tlb_if: lookup and fill signals of the TLB, grouped into one bundle.
//   Lookup side : virtual_address_i, privilege_i        -> phys_address_o,
//                 ready_o, tlb_miss_o (registered, one cycle later)
//   Fill side   : w_virtual_page_i, w_phys_page_i, write_enable_i
// Modports: master drives lookups and fills (address generation and miss
// handler); slave is the TLB itself.
interface tlb_if #(
    parameter int OFFSET         = 12,
    parameter int PHYS_ADDR_SIZE = 20
);
    logic [31:0]               virtual_address_i;
    logic                      privilege_i;
    logic [PHYS_ADDR_SIZE-1:0] phys_address_o;
    logic                      ready_o;
    logic                      tlb_miss_o;
    logic [31-OFFSET:0]        w_virtual_page_i;
    logic [31-OFFSET:0]        w_phys_page_i;
    logic                      write_enable_i;

    modport master (
        output virtual_address_i, privilege_i,
        output w_virtual_page_i, w_phys_page_i, write_enable_i,
        input  phys_address_o, ready_o, tlb_miss_o
    );

    modport slave (
        input  virtual_address_i, privilege_i,
        input  w_virtual_page_i, w_phys_page_i, write_enable_i,
        output phys_address_o, ready_o, tlb_miss_o
    );
endinterface

// File: rtl/tlb.sv
// tlb: fully associative translation lookaside buffer.
//   clock      : rising-edge clock
//   reset_n_i  : synchronous active-low reset (clears valid bits, pointer,
//                outputs; wins over a concurrent fill)
//   bus        : tlb_if.slave
//     lookup : virtual_address_i / privilege_i are translated every cycle;
//              phys_address_o, ready_o, tlb_miss_o are registered one cycle
//              later. Privileged accesses are identity-mapped.
//     fill   : write_enable_i installs w_virtual_page_i -> w_phys_page_i.
//              An existing valid mapping is updated in place; otherwise the
//              entry at the round-robin pointer is replaced.
module tlb #(
    parameter int OFFSET         = 12,
    parameter int PHYS_ADDR_SIZE = 20,
    parameter int ENTRIES        = 4
) (
    input  logic   clock,
    input  logic   reset_n_i,
    tlb_if.slave   bus
);
    localparam int VPN_W = 32 - OFFSET;
    localparam int PPN_W = PHYS_ADDR_SIZE - OFFSET;
    localparam int PTR_W = $clog2(ENTRIES);

    // Only the PPN bits that reach the physical address are kept.
    logic [ENTRIES-1:0] valid_reg;
    logic [VPN_W-1:0]   vpn_reg [ENTRIES];
    logic [PPN_W-1:0]   ppn_reg [ENTRIES];
    logic [PTR_W-1:0]   ptr_reg;

    logic [PHYS_ADDR_SIZE-1:0] phys_reg,  phys_next;
    logic                      ready_reg, ready_next;
    logic                      miss_reg,  miss_next;

    logic [VPN_W-1:0]   lookup_vpn;
    logic [OFFSET-1:0]  lookup_offset;
    logic [ENTRIES-1:0] hit_vec;
    logic [ENTRIES-1:0] wmatch_vec;
    logic               hit_any,   wmatch_any;
    logic [PTR_W-1:0]   hit_idx,   wmatch_idx;
    logic [PTR_W-1:0]   write_idx, ptr_next;

    assign lookup_vpn    = bus.virtual_address_i[31:OFFSET];
    assign lookup_offset = bus.virtual_address_i[OFFSET-1:0];

    // Parallel tag compare for the lookup and for the fill port.
    genvar gi;
    generate
        for (gi = 0; gi < ENTRIES; gi++) begin : g_cmp
            assign hit_vec[gi]    = valid_reg[gi] && (vpn_reg[gi] == lookup_vpn);
            assign wmatch_vec[gi] = valid_reg[gi] && (vpn_reg[gi] == bus.w_virtual_page_i);
        end

        if (PHYS_ADDR_SIZE < 32) begin : g_unused
            // Upper PPN bits can never reach the physical address.
            logic unused_ppn_bits;
            assign unused_ppn_bits = ^bus.w_phys_page_i[VPN_W-1:PPN_W];
        end
    endgenerate

    // Priority encoders: scanning downward lets the lowest index win if the
    // table ever held duplicates.
    always_comb begin
        hit_any    = 1'b0;
        hit_idx    = '0;
        wmatch_any = 1'b0;
        wmatch_idx = '0;
        for (int i = ENTRIES - 1; i >= 0; i--) begin
            if (hit_vec[i]) begin
                hit_any = 1'b1;
                hit_idx = PTR_W'(i);
            end
            if (wmatch_vec[i]) begin
                wmatch_any = 1'b1;
                wmatch_idx = PTR_W'(i);
            end
        end
    end

    // Refill target: update an existing mapping in place (pointer held),
    // otherwise replace the oldest slot and advance the FIFO pointer.
    // ENTRIES is a power of two, so the increment wraps on its own.
    always_comb begin
        write_idx = ptr_reg;
        ptr_next  = ptr_reg + PTR_W'(1);
        if (wmatch_any) begin
            write_idx = wmatch_idx;
            ptr_next  = ptr_reg;
        end
    end

    // Translation result for the registered outputs.
    always_comb begin
        phys_next  = '0;
        ready_next = 1'b0;
        miss_next  = 1'b0;
        if (bus.privilege_i) begin
            phys_next  = bus.virtual_address_i[PHYS_ADDR_SIZE-1:0];
            ready_next = 1'b1;
        end else if (hit_any) begin
            phys_next  = {ppn_reg[hit_idx], lookup_offset};
            ready_next = 1'b1;
        end else begin
            miss_next  = 1'b1;
        end
    end

    // Lookups read the table as it was before this edge's fill, so a new
    // entry becomes visible one cycle after it is written.
    always_ff @(posedge clock) begin
        if (!reset_n_i) begin
            valid_reg <= '0;
            ptr_reg   <= '0;
            phys_reg  <= '0;
            ready_reg <= 1'b0;
            miss_reg  <= 1'b0;
        end else begin
            if (bus.write_enable_i) begin
                valid_reg[write_idx] <= 1'b1;
                vpn_reg[write_idx]   <= bus.w_virtual_page_i;
                ppn_reg[write_idx]   <= bus.w_phys_page_i[PPN_W-1:0];
                ptr_reg              <= ptr_next;
            end
            phys_reg  <= phys_next;
            ready_reg <= ready_next;
            miss_reg  <= miss_next;
        end
    end

    assign bus.phys_address_o = phys_reg;
    assign bus.ready_o        = ready_reg;
    assign bus.tlb_miss_o     = miss_reg;
endmodule

// File: tb/tb_tlb.sv
// tb_tlb: directed test of tlb (OFFSET=12, PHYS_ADDR_SIZE=20, ENTRIES=4).
// Inputs change 1 time unit after each rising edge; outputs are sampled at
// the same point after the following edge.
module tb_tlb;
    logic clock;
    logic reset_n;
    int   n_checks;
    int   n_errors;

    tlb_if #(.OFFSET(12), .PHYS_ADDR_SIZE(20)) bus ();

    tlb #(.OFFSET(12), .PHYS_ADDR_SIZE(20), .ENTRIES(4)) dut (
        .clock     (clock),
        .reset_n_i (reset_n),
        .bus       (bus)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end else begin
            $display("ok   %s: 0x%08h", tag, got);
        end
    endtask

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    // One lookup cycle, then compare all three outputs.
    task automatic look(input string tag, input logic [31:0] va, input logic priv,
                        input logic [31:0] exp_phys, input logic exp_ready, input logic exp_miss);
        bus.virtual_address_i = va;
        bus.privilege_i       = priv;
        tick();
        check({tag, ".phys"},  32'(bus.phys_address_o), exp_phys);
        check({tag, ".ready"}, 32'(bus.ready_o),        32'(exp_ready));
        check({tag, ".miss"},  32'(bus.tlb_miss_o),     32'(exp_miss));
    endtask

    task automatic hit(input string tag, input logic [31:0] va, input logic [31:0] exp_phys);
        look(tag, va, 1'b0, exp_phys, 1'b1, 1'b0);
    endtask

    task automatic miss(input string tag, input logic [31:0] va);
        look(tag, va, 1'b0, 32'h0, 1'b0, 1'b1);
    endtask

    task automatic wr(input logic [19:0] vpn, input logic [19:0] ppn);
        bus.w_virtual_page_i = vpn;
        bus.w_phys_page_i    = ppn;
        bus.write_enable_i   = 1'b1;
        tick();
        bus.write_enable_i   = 1'b0;
    endtask

    initial begin
        n_checks = 0;
        n_errors = 0;
        reset_n  = 1'b0;
        bus.virtual_address_i = 32'h0000_1000;
        bus.privilege_i       = 1'b1;
        bus.w_virtual_page_i  = 20'h0;
        bus.w_phys_page_i     = 20'h0;
        bus.write_enable_i    = 1'b0;
        tick();
        tick();
        check("rst.phys",  32'(bus.phys_address_o), 32'h0);
        check("rst.ready", 32'(bus.ready_o),        32'h0);
        check("rst.miss",  32'(bus.tlb_miss_o),     32'h0);
        reset_n = 1'b1;

        // Empty table.
        miss("empty.va1000", 32'h0000_1000);
        look("priv.va1000", 32'h0000_1000, 1'b1, 32'h01000, 1'b1, 1'b0);

        // Fill inputs toggled without the enable must not install anything.
        bus.w_virtual_page_i = 20'h00001;
        bus.w_phys_page_i    = 20'h00007;
        bus.privilege_i      = 1'b0;
        tick();
        bus.w_virtual_page_i = 20'h00002;
        bus.w_phys_page_i    = 20'h0000F;
        miss("noen.vpn1", 32'h0000_1000);
        miss("noen.vpn2", 32'h0000_2000);

        // Install 2->4, 3->5, 4->6 while an unmapped address is looked up.
        bus.virtual_address_i = 32'h0002_D000;
        bus.privilege_i       = 1'b0;
        wr(20'h2, 20'h4);
        check("fill.miss_during", 32'(bus.tlb_miss_o), 32'h1);
        wr(20'h3, 20'h5);
        wr(20'h4, 20'h6);
        hit("hit.vpn2", 32'h0000_2000, 32'h04000);
        hit("hit.vpn3off", 32'h0000_3ABC, 32'h05ABC);
        look("priv.va2000", 32'h0000_2000, 1'b1, 32'h02000, 1'b1, 1'b0);
        miss("miss.highvpn", 32'h1234_5000);

        // In-place rewrite: pointer must stay on slot 3.
        wr(20'h3, 20'h9);
        hit("rewr.vpn3", 32'h0000_3000, 32'h09000);
        hit("rewr.vpn2", 32'h0000_2000, 32'h04000);
        hit("rewr.vpn4", 32'h0000_4000, 32'h06000);

        // Fill slot 3 with VPN 5, then wrap to slot 0 (evicts VPN 2).
        wr(20'h5, 20'h7);
        wr(20'h6, 20'h8);
        miss("wrap.vpn2", 32'h0000_2000);
        hit("wrap.vpn6", 32'h0000_6000, 32'h08000);
        hit("wrap.vpn3", 32'h0000_3000, 32'h09000);
        hit("wrap.vpn4", 32'h0000_4000, 32'h06000);
        hit("wrap.vpn5", 32'h0000_5000, 32'h07000);

        // Write VPN 7 while looking it up: old table seen, hit a cycle later.
        bus.virtual_address_i = 32'h0000_7000;
        bus.privilege_i       = 1'b0;
        wr(20'h7, 20'hA);
        check("same.miss",  32'(bus.tlb_miss_o),     32'h1);
        check("same.ready", 32'(bus.ready_o),        32'h0);
        hit("next.vpn7", 32'h0000_7000, 32'h0A000);

        // Slot 1 went to VPN 7 (evicted 3); slot 2 goes to VPN 8 (evicts 4).
        wr(20'h8, 20'hB);
        miss("evict.vpn3", 32'h0000_3000);
        miss("evict.vpn4", 32'h0000_4000);
        hit("keep.vpn5", 32'h0000_5000, 32'h07000);
        hit("keep.vpn6", 32'h0000_6000, 32'h08000);
        hit("keep.vpn8off", 32'h0000_8FFF, 32'h0BFFF);

        // Reset mid-operation with a fill pending: reset wins.
        bus.virtual_address_i = 32'h0000_5000;
        bus.privilege_i       = 1'b1;
        bus.w_virtual_page_i  = 20'h9;
        bus.w_phys_page_i     = 20'hC;
        bus.write_enable_i    = 1'b1;
        reset_n               = 1'b0;
        tick();
        check("mrst.phys",  32'(bus.phys_address_o), 32'h0);
        check("mrst.ready", 32'(bus.ready_o),        32'h0);
        check("mrst.miss",  32'(bus.tlb_miss_o),     32'h0);
        bus.write_enable_i = 1'b0;
        reset_n            = 1'b1;
        miss("post.vpn5", 32'h0000_5000);
        miss("post.vpn6", 32'h0000_6000);
        miss("post.vpn7", 32'h0000_7000);
        miss("post.vpn9", 32'h0000_9000);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end
endmodule
